// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg -- shared types and defaults for the PE sequencer.
//   pe_seq_state_e   : sequencer FSM state encoding
//   DRAIN_CYCLES_DEF : default multiply/accumulate pipeline drain depth
package pe_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_WAIT,
    ST_COMPUTE,
    ST_NEXT_FILT,
    ST_NEXT_ROW,
    ST_DRAIN,
    ST_DONE
  } pe_seq_state_e;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pe_seq_drain_timer.sv
// pe_seq_drain_timer -- loadable down-counter that times the pipeline drain.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : load CYCLES-1 (issued on the cycle before the drain starts)
//   en_i     : count down while draining
//   done_o   : terminal count reached (current cycle is the last drain cycle)
module pe_seq_drain_timer
  import pe_seq_pkg::*;
#(
  parameter int CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= W'(CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer -- job sequencer for a processing element datapath.
// Optional build macro: PE_SEQ_STALL_CNT_EN adds the stall_cycles output.
//
// state      | meaning
// -----------+----------------------------------------------
// IDLE       | waiting for start, captures job config
// CONFIG     | load stride/filter size, clear accumulator
// WAIT       | wait for first data and filter availability
// COMPUTE    | issue puts while data and filter available
// NEXT_FILT  | advance to next filter in the row
// NEXT_ROW   | advance to next ifmap row, count rows
// DRAIN      | let MAC pipeline empty (DRAIN_CYCLES cycles)
// DONE       | one-cycle completion pulse
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : job request pulse, cancel current job
//   cfg_*               : job configuration, sampled on accepted start
//   av_data, av_filter, co_filter, end_of_row, end_of_filter : datapath status
//   ld_stride, ld_fileSize, clear_sum, put_data, put_filter,
//   next_filter, next_row : datapath controls
//   stride_out, filter_size_out : captured configuration
//   chip_en, busy, done : enable, job active, completion pulse
//   stall_cycles        : (PE_SEQ_STALL_CNT_EN only) COMPUTE cycles without a put
module pe_sequencer
  import pe_seq_pkg::*;
#(
  parameter int STRIDE_SIZE          = 3,
  parameter int FILTER_SIZE_REG_SIZE = 8,
  parameter int ROW_CNT_WIDTH        = 8,
  parameter int DRAIN_CYCLES         = DRAIN_CYCLES_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [STRIDE_SIZE-1:0]          cfg_stride,
  input  logic [FILTER_SIZE_REG_SIZE-1:0] cfg_filter_size,
  input  logic [ROW_CNT_WIDTH-1:0]        cfg_num_rows,
  input  logic                            av_data,
  input  logic                            av_filter,
  input  logic                            co_filter,
  input  logic                            end_of_row,
  input  logic                            end_of_filter,
  output logic                            ld_stride,
  output logic                            ld_fileSize,
  output logic                            clear_sum,
  output logic                            put_data,
  output logic                            put_filter,
  output logic                            next_filter,
  output logic                            next_row,
  output logic [STRIDE_SIZE-1:0]          stride_out,
  output logic [FILTER_SIZE_REG_SIZE-1:0] filter_size_out,
`ifdef PE_SEQ_STALL_CNT_EN
  output logic [15:0]                     stall_cycles,
`endif
  output logic                            chip_en,
  output logic                            busy,
  output logic                            done
);

  pe_seq_state_e                   state_q, state_d;
  logic [STRIDE_SIZE-1:0]          stride_q;
  logic [FILTER_SIZE_REG_SIZE-1:0] filt_q;
  logic [ROW_CNT_WIDTH-1:0]        rows_q;
  logic [ROW_CNT_WIDTH-1:0]        row_cnt_q;
  logic [ROW_CNT_WIDTH-1:0]        last_row;
  logic                            avail;
  logic                            row_inc;
  logic                            tmr_load;
  logic                            tmr_en;
  logic                            tmr_done;

  assign avail = av_data && av_filter;
  // A zero row count runs a single row; counter stays below rows_q so it never wraps.
  assign last_row = (rows_q == '0) ? '0 : rows_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stride_q  <= '0;
      filt_q    <= '0;
      rows_q    <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        stride_q <= cfg_stride;
        filt_q   <= cfg_filter_size;
        rows_q   <= cfg_num_rows;
      end
      if (state_q == ST_CONFIG) begin
        row_cnt_q <= '0;
      end else if (row_inc) begin
        row_cnt_q <= row_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_stride   = 1'b0;
    ld_fileSize = 1'b0;
    clear_sum   = 1'b0;
    put_data    = 1'b0;
    put_filter  = 1'b0;
    next_filter = 1'b0;
    next_row    = 1'b0;
    done        = 1'b0;
    row_inc     = 1'b0;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CONFIG;
      ST_CONFIG: begin
        ld_stride   = 1'b1;
        ld_fileSize = 1'b1;
        clear_sum   = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: if (avail) state_d = ST_COMPUTE;
      ST_COMPUTE: begin
        put_data   = avail;
        put_filter = avail;
        if (avail && co_filter && end_of_filter) begin
          state_d = end_of_row ? ST_NEXT_ROW : ST_NEXT_FILT;
        end
      end
      ST_NEXT_FILT: begin
        next_filter = 1'b1;
        state_d     = ST_COMPUTE;
      end
      ST_NEXT_ROW: begin
        next_row = 1'b1;
        row_inc  = 1'b1;
        if (row_cnt_q == last_row) begin
          tmr_load = 1'b1;
          state_d  = ST_DRAIN;
        end else begin
          state_d = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        tmr_en = 1'b1;
        if (tmr_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything: only the accumulator clear is issued.
    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      ld_stride   = 1'b0;
      ld_fileSize = 1'b0;
      clear_sum   = 1'b1;
      put_data    = 1'b0;
      put_filter  = 1'b0;
      next_filter = 1'b0;
      next_row    = 1'b0;
      done        = 1'b0;
      row_inc     = 1'b0;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
    end
  end

  pe_seq_drain_timer #(
    .CYCLES (DRAIN_CYCLES)
  ) u_drain_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == ST_CONFIG) begin
      stall_q <= '0;
    end else if (state_q == ST_COMPUTE && !avail && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

  assign busy            = (state_q != ST_IDLE);
  assign chip_en         = busy;
  assign stride_out      = stride_q;
  assign filter_size_out = filt_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer -- directed self-checking bench for pe_sequencer.
// Honours PE_SEQ_STALL_CNT_EN when the design is built with it.
module tb_pe_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] cfg_stride = '0;
  logic [7:0] cfg_filter_size = '0;
  logic [7:0] cfg_num_rows = '0;
  logic       av_data = 1'b1;
  logic       av_filter = 1'b1;
  logic       co_filter, end_of_row, end_of_filter;
  logic       ld_stride, ld_fileSize, clear_sum, put_data, put_filter;
  logic       next_filter, next_row, chip_en, busy, done;
  logic [2:0] stride_out;
  logic [7:0] filter_size_out;
`ifdef PE_SEQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg_stride      (cfg_stride),
    .cfg_filter_size (cfg_filter_size),
    .cfg_num_rows    (cfg_num_rows),
    .av_data         (av_data),
    .av_filter       (av_filter),
    .co_filter       (co_filter),
    .end_of_row      (end_of_row),
    .end_of_filter   (end_of_filter),
    .ld_stride       (ld_stride),
    .ld_fileSize     (ld_fileSize),
    .clear_sum       (clear_sum),
    .put_data        (put_data),
    .put_filter      (put_filter),
    .next_filter     (next_filter),
    .next_row        (next_row),
    .stride_out      (stride_out),
    .filter_size_out (filter_size_out),
`ifdef PE_SEQ_STALL_CNT_EN
    .stall_cycles    (stall_cycles),
`endif
    .chip_en         (chip_en),
    .busy            (busy),
    .done            (done)
  );

  // Datapath model: a filter is flen puts long, a row holds nfilt filters.
  int flen = 1;
  int nfilt = 1;
  int pc = 0;
  int fc = 0;

  assign co_filter     = (pc == flen - 1);
  assign end_of_filter = (pc == flen - 1);
  assign end_of_row    = end_of_filter && (fc == nfilt - 1);

  always @(posedge clk) begin
    if (!busy) begin
      pc <= 0;
      fc <= 0;
    end else if (put_data && end_of_filter) begin
      pc <= 0;
      fc <= end_of_row ? 0 : fc + 1;
    end else if (put_data) begin
      pc <= pc + 1;
    end
  end

  // Event counters, sampled mid-cycle.
  int n_put = 0, n_nf = 0, n_nr = 0, n_done = 0, n_cs = 0, n_ld = 0;

  always @(negedge clk) begin
    if (put_data)    n_put  <= n_put + 1;
    if (next_filter) n_nf   <= n_nf + 1;
    if (next_row)    n_nr   <= n_nr + 1;
    if (done)        n_done <= n_done + 1;
    if (clear_sum)   n_cs   <= n_cs + 1;
    if (ld_stride)   n_ld   <= n_ld + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int st, input int fs, input int rows, input int fl, input int nf);
    cfg_stride      = 3'(st);
    cfg_filter_size = 8'(fs);
    cfg_num_rows    = 8'(rows);
    flen            = fl;
    nfilt           = nf;
    start           = 1'b1;
    tick();
    start           = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 1);
  endtask

  int n, b_put, b_nf, b_nr, b_done, b_cs;

  task automatic snap();
    #4;  // let the negedge counters settle before taking a baseline
    b_put = n_put; b_nf = n_nf; b_nr = n_nr; b_done = n_done; b_cs = n_cs;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_chip_en", 32'(chip_en), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stride", 32'(stride_out), 0);
    rst = 1'b0;
    tick();

    // Basic job: stride 2, filter 3, one row, 3 puts then drain
    snap();
    start_job(2, 3, 1, 3, 1);
    chk("cfg_ld_stride", 32'(ld_stride), 1);
    chk("cfg_ld_filesize", 32'(ld_fileSize), 1);
    chk("cfg_clear_sum", 32'(clear_sum), 1);
    chk("cfg_stride_out", 32'(stride_out), 2);
    chk("cfg_filter_out", 32'(filter_size_out), 3);
    tick();
    chk("wait_ld_stride", 32'(ld_stride), 0);
    chk("wait_put", 32'(put_data), 0);
    tick();
    chk("comp_put_data", 32'(put_data), 1);
    chk("comp_put_filter", 32'(put_filter), 1);
    tick(); tick(); tick();
    chk("next_row_pulse", 32'(next_row), 1);
    wait_done("job1_done", 20, n);
    chk("job1_drain_len", 32'(n), 4);
    chk("job1_puts", 32'(n_put - b_put), 3);
    tick();
    chk("job1_idle", 32'(busy), 0);
    chk("job1_done_once", 32'(n_done - b_done), 1);

    // Stall: av_data low for 4 cycles mid-COMPUTE
    snap();
    start_job(1, 8, 1, 8, 1);
    tick(); tick();
    tick();
    av_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_put", 32'(put_data), 0);
      chk("stall_busy", 32'(busy), 1);
      tick();
    end
    av_data = 1'b1;
    #1;
    chk("stall_resume_put", 32'(put_data), 1);
    wait_done("stall_done", 40, n);
    chk("stall_puts", 32'(n_put - b_put), 8);
`ifdef PE_SEQ_STALL_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), 4);
`endif
    tick();

    // Three rows, two filters per row, two puts per filter
    snap();
    start_job(1, 2, 3, 2, 2);
    wait_done("rows3_done", 100, n);
    tick();
    chk("rows3_next_filter", 32'(n_nf - b_nf), 3);
    chk("rows3_next_row", 32'(n_nr - b_nr), 3);
    chk("rows3_puts", 32'(n_put - b_put), 12);
    chk("rows3_done_once", 32'(n_done - b_done), 1);

    // Abort during COMPUTE
    snap();
    start_job(3, 4, 2, 4, 1);
    tick(); tick(); tick();
    abort = 1'b1;
    #1;
    chk("abort_clear_sum", 32'(clear_sum), 1);
    tick();
    abort = 1'b0;
    #1;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_clear_sum_off", 32'(clear_sum), 0);
    tick(); tick(); tick();
    chk("abort_no_done", 32'(n_done - b_done), 0);
    chk("abort_clear_cnt", 32'(n_cs - b_cs), 2);

    // Reset during DRAIN, then immediate restart
    start_job(4, 5, 1, 1, 1);
    tick(); tick(); tick(); tick();
    chk("drain_busy", 32'(busy), 1);
    chk("drain_no_put", 32'(put_data), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_chip_en", 32'(chip_en), 0);
    chk("rstmid_stride", 32'(stride_out), 0);
    chk("rstmid_filter", 32'(filter_size_out), 0);
    chk("rstmid_clear_sum", 32'(clear_sum), 0);
`ifdef PE_SEQ_STALL_CNT_EN
    chk("rstmid_stall", 32'(stall_cycles), 0);
`endif
    snap();
    start_job(5, 7, 1, 1, 1);
    chk("restart_ld", 32'(ld_stride), 1);
    chk("restart_stride", 32'(stride_out), 5);
    wait_done("restart_done", 20, n);
    tick();

    // Start while busy is ignored
    snap();
    start_job(1, 2, 1, 3, 1);
    tick(); tick();
    start           = 1'b1;
    cfg_stride      = 3'd6;
    cfg_filter_size = 8'd9;
    tick();
    start = 1'b0;
    chk("busy_start_stride", 32'(stride_out), 1);
    chk("busy_start_filter", 32'(filter_size_out), 2);
    wait_done("busy_start_done", 30, n);
    tick(); tick(); tick();
    chk("busy_start_idle", 32'(busy), 0);
    chk("busy_start_one_done", 32'(n_done - b_done), 1);

    // Zero rows runs as one row
    snap();
    start_job(1, 1, 0, 1, 1);
    wait_done("rows0_done", 20, n);
    tick();
    chk("rows0_next_row", 32'(n_nr - b_nr), 1);

    // Maximum row count, no wrap
    snap();
    start_job(1, 1, 255, 1, 1);
    wait_done("rows255_done", 2000, n);
    tick();
    chk("rows255_next_row", 32'(n_nr - b_nr), 255);
    chk("rows255_done_once", 32'(n_done - b_done), 1);
    chk("rows255_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 Param STRIDE_SIZE, 3, stride field width.
REQ-002 Param FILTER_SIZE_REG_SIZE, 8, filter-size field width.
REQ-003 Param ROW_CNT_WIDTH, 8, row-count field width.
REQ-004 Param DRAIN_CYCLES, 3, pipeline drain wait (multiply/accumulate stages).
REQ-005 The module SHALL use one clock `clk`; reset `rst` is synchronous and active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  sync active-high reset.
REQ-008 start  in  1  job request pulse.
REQ-009 abort  in  1  cancel current job.
REQ-010 cfg_stride  in  STRIDE_SIZE  stride for job.
REQ-011 cfg_filter_size  in  FILTER_SIZE_REG_SIZE  filter length for job.
REQ-012 cfg_num_rows  in  ROW_CNT_WIDTH  ifmap rows in job (0 treated as 1).
REQ-013 av_data, av_filter, co_filter, end_of_row, end_of_filter  in  1 each  datapath status.
REQ-014 ld_stride, ld_fileSize, clear_sum, put_data, put_filter, next_filter, next_row  out  1 each  datapath controls.
REQ-015 stride_out  out  STRIDE_SIZE  and  filter_size_out  out  FILTER_SIZE_REG_SIZE: captured config, valid while ld_* high.
REQ-016 chip_en, busy, done  out  1 each  enable, job active, completion pulse.

Function
REQ-017 States SHALL be IDLE, CONFIG, WAIT, COMPUTE, NEXT_FILT, NEXT_ROW, DRAIN, DONE; all outputs Moore except put_data/put_filter.
REQ-018 IDLE: start=1 SHALL capture cfg_* and go to CONFIG; start while not IDLE ignored.
REQ-019 CONFIG (1 cycle): ld_stride=ld_fileSize=clear_sum=1, row counter cleared, then WAIT.
REQ-020 WAIT: av_data&&av_filter SHALL move to COMPUTE next cycle.
REQ-021 COMPUTE: put_data=put_filter=(av_data&&av_filter), same cycle; stall (both 0, stay) when either unavailable.
REQ-022 COMPUTE with put and co_filter=1: end_of_filter&&end_of_row -> NEXT_ROW; end_of_filter only -> NEXT_FILT; else stay.
REQ-023 NEXT_FILT (1 cycle): next_filter=1, then COMPUTE.
REQ-024 NEXT_ROW (1 cycle): next_row=1, row counter +1; if counter was max(cfg_num_rows,1)-1 -> DRAIN else COMPUTE.
REQ-025 DRAIN: exactly DRAIN_CYCLES cycles, no put; then DONE.
REQ-026 DONE (1 cycle): done=1, then IDLE.
REQ-027 busy=1 in every state except IDLE; chip_en=busy.
REQ-028 abort in any non-IDLE state SHALL force IDLE next cycle with clear_sum=1 that cycle; no done pulse; abort has priority over all transitions.
REQ-029 Row counter SHALL not wrap: cfg_num_rows=2^ROW_CNT_WIDTH-1 completes correctly.

Reset
REQ-030 rst SHALL force IDLE, clear counters and captured config; all outputs 0 next cycle, including mid-job.

Configuration
REQ-031 With PE_SEQ_STALL_CNT_EN defined: extra output stall_cycles (16 bits), cleared in CONFIG, +1 each COMPUTE cycle with put=0, saturating at 16'hFFFF; undefined: port absent, no logic.

Structure
REQ-032 Package pe_seq_pkg SHALL hold the state enum typedef and default DRAIN_CYCLES constant.
REQ-033 One sub-module pe_seq_drain_timer (loadable down-counter, done flag) SHALL implement DRAIN.

Verification
REQ-034 start, stride=2, filter=3, rows=1, av_* always 1, co_filter/end_of_filter/end_of_row at put #3 -> ld_* pulse cycle 1, 3 puts, next_row, DRAIN 3 cycles, done pulse.
REQ-035 av_data low 4 cycles mid-COMPUTE -> put_data=0 for those 4 cycles, state held; stall_cycles=4 when macro set.
REQ-036 rows=3, two filters per row -> next_filter x3, next_row x3, one done.
REQ-037 abort during COMPUTE -> IDLE next cycle, clear_sum=1 once, done never asserted.
REQ-038 rst during DRAIN -> all outputs 0 next cycle, new start accepted immediately after.
REQ-039 start asserted while busy -> ignored, config unchanged, single done.
